// File: rtl/uart_rx_capture.sv
// uart_rx_capture
//   16x-oversampling UART receiver (8 data bits, LSB first, 1 stop bit)
//   that pushes every good byte into a small first-word-fall-through FIFO.
//
//   Optional feature macro: UART_RX_PARITY_EN
//     When defined, one even-parity bit follows the data bits, and the
//     sticky output parity_err exists. A byte with bad parity is discarded.
//     The stop bit is still checked for that frame.
//
// Parameters
//   CLK_DIV    : sys_clk cycles per 16x oversample tick
//   FIFO_DEPTH : receive FIFO entries (power of two, >= 2)
//
// Ports
//   sys_clk    : the only clock, rising edge
//   sys_rst    : asynchronous, active-high reset
//   uart_rx    : serial input, idle high (asynchronous to sys_clk)
//   out_data   : byte at the FIFO head (0 when the FIFO is empty)
//   out_valid  : FIFO non-empty
//   out_ready  : consumer takes the head byte when out_valid is also high
//   fifo_count : number of bytes held
//   frame_err  : sticky, a stop bit was sampled low
//   overrun    : sticky, a byte was dropped because the FIFO was full
//   parity_err : sticky, parity mismatch (only with UART_RX_PARITY_EN)
//   err_clr    : one-cycle clear of all sticky flags (a new error wins)

module uart_rx_capture #(
  parameter int CLK_DIV    = 54,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  input  logic                        uart_rx,
  output logic [7:0]                  out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        frame_err,
  output logic                        overrun,
`ifdef UART_RX_PARITY_EN
  output logic                        parity_err,
`endif
  input  logic                        err_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  // Synchronizer resets to the idle line level so reset never looks like a start bit.
  logic rx_meta_reg, rx_sync_reg;
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
    end else begin
      rx_meta_reg <= uart_rx;
      rx_sync_reg <= rx_meta_reg;
    end
  end

  // Free-running oversample divider.
  logic [DW-1:0] div_cnt_reg;
  logic          tick;
  assign tick = (div_cnt_reg == DW'(CLK_DIV - 1));
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) div_cnt_reg <= '0;
    else         div_cnt_reg <= tick ? '0 : div_cnt_reg + 1'b1;
  end

  // Receiver FSM. The 4-bit tick counter wraps 15 -> 0 on its own, so each
  // 16-tick bit period ends exactly when the counter reads 15.
  state_t     state_reg, state_next;
  logic [3:0] tick_cnt_reg, tick_cnt_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0] shift_reg, shift_next;
  logic       push, set_frame_err;
`ifdef UART_RX_PARITY_EN
  logic       par_bad_reg, par_bad_next, set_parity_err;
`endif

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg    <= IDLE;
      tick_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad_reg  <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      tick_cnt_reg <= tick_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
`ifdef UART_RX_PARITY_EN
      par_bad_reg  <= par_bad_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    tick_cnt_next = tick_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    push          = 1'b0;
    set_frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_next   = par_bad_reg;
    set_parity_err = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (tick && !rx_sync_reg) begin
          tick_cnt_next = '0;
          bit_cnt_next  = '0;
`ifdef UART_RX_PARITY_EN
          par_bad_next  = 1'b0;
`endif
          state_next    = START;
        end
      end
      START: begin
        // Re-check the line half a bit in; a high here was only a glitch.
        if (tick) begin
          tick_cnt_next = tick_cnt_reg + 4'd1;
          if (tick_cnt_reg == 4'd7) begin
            tick_cnt_next = '0;
            state_next    = rx_sync_reg ? IDLE : DATA;
          end
        end
      end
      DATA: begin
        if (tick) begin
          tick_cnt_next = tick_cnt_reg + 4'd1;
          if (tick_cnt_reg == 4'd15) begin
            shift_next   = {rx_sync_reg, shift_reg[7:1]};
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        // Even parity: the parity bit equals the XOR of the data bits.
        if (tick) begin
          tick_cnt_next = tick_cnt_reg + 4'd1;
          if (tick_cnt_reg == 4'd15) begin
            if (rx_sync_reg != ^shift_reg) begin
              par_bad_next   = 1'b1;
              set_parity_err = 1'b1;
            end
            state_next = STOP;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          tick_cnt_next = tick_cnt_reg + 4'd1;
          if (tick_cnt_reg == 4'd15) begin
            if (rx_sync_reg) begin
`ifdef UART_RX_PARITY_EN
              push = !par_bad_reg;
`else
              push = 1'b1;
`endif
              state_next = IDLE;
            end else begin
              set_frame_err = 1'b1;
              state_next    = BREAK;
            end
          end
        end
      end
      BREAK: begin
        if (rx_sync_reg) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FIFO: extra pointer MSB distinguishes full from empty.
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_reg, rd_ptr_reg;
  logic        full, do_pop, do_write, set_overrun;

  assign full        = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign out_valid   = (wr_ptr_reg != rd_ptr_reg);
  assign fifo_count  = wr_ptr_reg - rd_ptr_reg;
  assign do_pop      = out_valid && out_ready;
  // When full, a simultaneous pop frees the slot being written this cycle.
  assign do_write    = push && (!full || do_pop);
  assign set_overrun = push && full && !do_pop;
  assign out_data    = out_valid ? mem[rd_ptr_reg[AW-1:0]] : 8'h00;

  always_ff @(posedge sys_clk) begin
    if (do_write) mem[wr_ptr_reg[AW-1:0]] <= shift_reg;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_write) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Sticky flags: a new error in the same cycle as err_clr keeps the flag set.
  logic frame_err_reg, overrun_reg;
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      frame_err_reg <= set_frame_err || (frame_err_reg && !err_clr);
      overrun_reg   <= set_overrun   || (overrun_reg   && !err_clr);
    end
  end
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;

`ifdef UART_RX_PARITY_EN
  logic parity_err_reg;
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) parity_err_reg <= 1'b0;
    else         parity_err_reg <= set_parity_err || (parity_err_reg && !err_clr);
  end
  assign parity_err = parity_err_reg;
`endif

endmodule

// File: tb/tb_uart_rx_capture.sv
// Directed testbench for uart_rx_capture (CLK_DIV=4, one bit = 64 cycles).
module tb_uart_rx_capture;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       uart_rx;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] fifo_count;
  logic       frame_err;
  logic       overrun;
  logic       err_clr;

  int checks = 0;
  int errors = 0;
  int valid_cycles = 0;
  int pop_count = 0;
  logic [7:0] last_pop = 8'h00;

  uart_rx_capture #(.CLK_DIV(4), .FIFO_DEPTH(8)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .uart_rx    (uart_rx),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_count (fifo_count),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .err_clr    (err_clr)
  );

  always #5 sys_clk = ~sys_clk;

  // Inputs change at the falling edge; observe 1 time unit later.
  always @(negedge sys_clk) begin
    #1;
    if (out_valid) valid_cycles++;
    if (out_valid && out_ready) begin
      pop_count++;
      last_pop = out_data;
    end
  end

  // One frame: start, 8 data bits LSB first, stop. A good stop bit is
  // followed by one idle bit time (704 cycles total, a multiple of the tick
  // period). A bad stop bit leaves the line low on return.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (64) @(negedge sys_clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (64) @(negedge sys_clk);
    end
    uart_rx = stop_bit;
    repeat (64) @(negedge sys_clk);
    if (stop_bit) begin
      uart_rx = 1'b1;
      repeat (64) @(negedge sys_clk);
    end
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge sys_clk);
    err_clr = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || fifo_count !== 4'd0) begin
      errors++;
      $display("FAIL reset_fifo got valid=%b data=%h count=%0d want 0 00 0", out_valid, out_data, fifo_count);
    end
    checks++;
    if (frame_err !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got frame_err=%b overrun=%b want 0 0", frame_err, overrun);
    end
    $display("test_reset done");
  endtask

  task automatic test_single_byte();
    int v0, p0;
    out_ready = 1'b1;
    v0 = valid_cycles;
    p0 = pop_count;
    send_frame(8'h55, 1'b1);
    checks++;
    if (valid_cycles - v0 !== 1) begin
      errors++;
      $display("FAIL single_valid_cycles got %0d want 1", valid_cycles - v0);
    end
    checks++;
    if (pop_count - p0 !== 1 || last_pop !== 8'h55) begin
      errors++;
      $display("FAIL single_data got pops=%0d data=%h want 1 55", pop_count - p0, last_pop);
    end
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL single_frame_err got %b want 0", frame_err);
    end
    $display("test_single_byte sent 55");
  endtask

  task automatic test_overrun();
    out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1);
    checks++;
    if (fifo_count !== 4'd8) begin
      errors++;
      $display("FAIL overrun_count got %0d want 8", fifo_count);
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_flag got %b want 1", overrun);
    end
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'(i)) begin
        errors++;
        $display("FAIL overrun_pop%0d got valid=%b data=%h want 1 %h", i, out_valid, out_data, 8'(i));
      end
      out_ready = 1'b1;
      @(negedge sys_clk);
      out_ready = 1'b0;
    end
    checks++;
    if (fifo_count !== 4'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL overrun_drained got count=%0d valid=%b want 0 0", fifo_count, out_valid);
    end
    pulse_clr();
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear got %b want 0", overrun);
    end
    $display("test_overrun sent 01..09");
  endtask

  task automatic test_frame_error();
    int p0;
    out_ready = 1'b1;
    p0 = pop_count;
    send_frame(8'hA5, 1'b0);
    repeat (200) @(negedge sys_clk);
    uart_rx = 1'b1;
    repeat (64) @(negedge sys_clk);
    checks++;
    if (frame_err !== 1'b1) begin
      errors++;
      $display("FAIL ferr_flag got %b want 1", frame_err);
    end
    checks++;
    if (fifo_count !== 4'd0 || pop_count - p0 !== 0) begin
      errors++;
      $display("FAIL ferr_discard got count=%0d pops=%0d want 0 0", fifo_count, pop_count - p0);
    end
    send_frame(8'h3C, 1'b1);
    checks++;
    if (pop_count - p0 !== 1 || last_pop !== 8'h3C) begin
      errors++;
      $display("FAIL ferr_next got pops=%0d data=%h want 1 3c", pop_count - p0, last_pop);
    end
    pulse_clr();
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL ferr_clear got %b want 0", frame_err);
    end
    $display("test_frame_error sent a5(bad stop) then 3c");
  endtask

  task automatic test_glitch();
    int p0;
    out_ready = 1'b1;
    p0 = pop_count;
    uart_rx = 1'b0;
    repeat (20) @(negedge sys_clk);
    uart_rx = 1'b1;
    repeat (200) @(negedge sys_clk);
    checks++;
    if (fifo_count !== 4'd0 || pop_count - p0 !== 0) begin
      errors++;
      $display("FAIL glitch_push got count=%0d pops=%0d want 0 0", fifo_count, pop_count - p0);
    end
    send_frame(8'h5A, 1'b1);
    checks++;
    if (pop_count - p0 !== 1 || last_pop !== 8'h5A) begin
      errors++;
      $display("FAIL glitch_recover got pops=%0d data=%h want 1 5a", pop_count - p0, last_pop);
    end
    $display("test_glitch 20-cycle low pulse then 5a");
  endtask

  // Frames are 704 cycles apart, so the push lands at the same offset in
  // every frame; the offset measured on the filling frame positions the
  // single-cycle out_ready for the 0x77 frame.
  task automatic test_full_push_pop();
    int n;
    logic [7:0] exp;
    out_ready = 1'b0;
    pulse_clr();
    for (int i = 0; i < 7; i++) send_frame(8'h21 + 8'(i), 1'b1);
    n = 0;
    fork
      send_frame(8'h28, 1'b1);
      begin
        while (fifo_count !== 4'd8 && n < 1000) begin
          @(negedge sys_clk);
          n++;
        end
      end
    join
    checks++;
    if (n >= 1000) begin
      errors++;
      $display("FAIL full_fill got count=%0d want 8 within 1000 cycles", fifo_count);
    end
    fork
      send_frame(8'h77, 1'b1);
      begin
        repeat (n - 1) @(negedge sys_clk);
        out_ready = 1'b1;
        @(negedge sys_clk);
        out_ready = 1'b0;
        checks++;
        if (fifo_count !== 4'd8 || out_data !== 8'h22) begin
          errors++;
          $display("FAIL full_pushpop got count=%0d head=%h want 8 22", fifo_count, out_data);
        end
      end
    join
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL full_overrun got %b want 0", overrun);
    end
    for (int i = 0; i < 8; i++) begin
      exp = (i < 7) ? 8'h22 + 8'(i) : 8'h77;
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp) begin
        errors++;
        $display("FAIL full_drain%0d got valid=%b data=%h want 1 %h", i, out_valid, out_data, exp);
      end
      out_ready = 1'b1;
      @(negedge sys_clk);
      out_ready = 1'b0;
    end
    $display("test_full_push_pop 21..28 then 77 with pop at push");
  endtask

  task automatic test_reset_mid_frame();
    int p0;
    out_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    checks++;
    if (fifo_count !== 4'd1 || out_data !== 8'h11) begin
      errors++;
      $display("FAIL rstmid_pre got count=%0d data=%h want 1 11", fifo_count, out_data);
    end
    fork
      send_frame(8'hF0, 1'b1);
      begin
        repeat (64 * 5 + 32) @(negedge sys_clk);
        sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || fifo_count !== 4'd0 ||
            frame_err !== 1'b0 || overrun !== 1'b0) begin
          errors++;
          $display("FAIL rstmid_outputs got valid=%b data=%h count=%0d ferr=%b ovr=%b want all 0",
                   out_valid, out_data, fifo_count, frame_err, overrun);
        end
        sys_rst = 1'b0;
      end
    join
    checks++;
    if (fifo_count !== 4'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_nopush got count=%0d valid=%b want 0 0", fifo_count, out_valid);
    end
    out_ready = 1'b1;
    p0 = pop_count;
    send_frame(8'h12, 1'b1);
    checks++;
    if (pop_count - p0 !== 1 || last_pop !== 8'h12) begin
      errors++;
      $display("FAIL rstmid_next got pops=%0d data=%h want 1 12", pop_count - p0, last_pop);
    end
    $display("test_reset_mid_frame f0 aborted then 12");
  endtask

  initial begin
    sys_rst   = 1'b1;
    uart_rx   = 1'b1;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    repeat (5) @(negedge sys_clk);
    test_reset();
    sys_rst = 1'b0;
    repeat (10) @(negedge sys_clk);
    test_reset();
    test_single_byte();
    test_overrun();
    test_frame_error();
    test_glitch();
    test_full_push_pop();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
